player_move_arbiter: RTL and testbench
======================================

Name: player_move_arbiter

Overview:
- Schedules player actions onto the shared game grid. Up to 4 player inputs (local buttons plus networked players) share this block.
- Once per game tick it serves pending move/chop requests in round-robin order. For each move it reads the grid through one shared read port, rejects moves into blocked or occupied tiles, and updates each player's position and facing.
- Sits between the debounced input / network receive logic and the game-state and graphics blocks.

Parameters:
- TICK_CYCLES, 1083333: clock cycles per game tick (60 Hz at 65 MHz).
- GRID_W, 13: grid columns; legal x is 0..GRID_W-1.
- GRID_H, 9: grid rows; legal y is 0..GRID_H-1.

Ports:
- clock_in  input  1  system clock.
- reset_in  input  1  synchronous, active-low reset.
- num_players  input  2  active player count minus 1. Players 0..num_players are active.
- req_valid  input  4  one-cycle request pulse per player.
- req_dir  input  8  2 bits per player [2i+1:2i]: 00 up, 01 right, 10 down, 11 left.
- req_chop  input  4  per player, qualified by req_valid: 1 = chop/interact, 0 = move.
- grid_rd_x  output  4  grid read address x.
- grid_rd_y  output  4  grid read address y.
- grid_blocked  input  1  tile at the address presented the previous cycle is non-walkable.
- pos_x  output  16  4 bits per player, current x.
- pos_y  output  16  4 bits per player, current y.
- facing  output  8  2 bits per player, current facing.
- ack  output  4  one-cycle pulse when player i's request is served.
- blocked  output  4  result of player i's last move; 1 = rejected. Held until the next serve of that player.
- chop_valid  output  1  one-cycle pulse for a served chop.
- chop_player  output  2  player issuing the chop.
- chop_x  output  4  x of the tile faced by the chopping player.
- chop_y  output  4  y of the tile faced by the chopping player.
- tick  output  1  one-cycle pulse at the start of each tick.
- busy  output  1  high while the FSM is not IDLE.

Behaviour:
Reset (reset_in==0 at a clock edge):
- Player i goes to (1+2i, 1) with facing 10.
- Pending flags, ack, blocked, chop_valid, tick, busy and grid_rd_* all go to 0.
- rr_ptr goes to 0, the tick counter to 0, and the FSM to IDLE.
- Reset mid-sweep abandons the sweep; no partial commit occurs.

Request capture:
- req_valid[i] with i <= num_players sets pending[i] and latches dir/chop for player i.
- A later request before service overwrites the latched one (latest wins).
- Requests from inactive players are ignored. Their pending flags are cleared whenever num_players changes.

Tick:
- The counter counts 0..TICK_CYCLES-1.
- At the wrap, tick pulses. If in IDLE, the FSM snapshots pending into a serve mask and enters SCAN.
- If a tick arrives while not IDLE (not reachable with legal parameters), it is dropped.

FSM:
- IDLE: waits for tick.
- SCAN:
  - Picks the first set serve-mask bit, searching from rr_ptr upward with wrap mod 4.
  - If the mask is empty: go to IDLE and rr_ptr <= rr_ptr+1 (mod 4).
  - If a chop is picked: emit chop_valid, chop_player and the faced tile; facing is unchanged; no grid read; pulse ack; clear the mask and pending bits; stay in SCAN.
  - If a move is picked: compute the target (pos + dir), drive grid_rd_x/y with it, and go to LOOKUP.
- LOOKUP: one wait cycle; grid_blocked is valid in the next cycle.
- CHECK: the move is rejected if any of the following holds:
  - grid_blocked is high;
  - the target is out of bounds (x or y below 0 via underflow, x >= GRID_W, or y >= GRID_H);
  - the target equals the current position of another active player.
  - Facing is always updated to the request dir.
  - Position updates only if not rejected; blocked[i] is set to the reject result.
  - Then pulse ack[i], clear mask[i] and pending[i] (unless a new req_valid for i arrives in that same cycle, which keeps it pending for the next tick), and return to SCAN.
- A chop at a grid edge emits the out-of-range faced coordinate unchanged, 4-bit wrapped. The consumer discards it.

Timing and arithmetic:
- Latency from tick to a move commit for the k-th served player is at most 3k+1 cycles. A full sweep takes at most 13 cycles.
- Arithmetic is 4-bit unsigned. Underflow of 0-1 gives 15, which is caught as out of bounds.
- Players are served sequentially, so a later-served player sees earlier commits. Two players targeting the same empty tile: the first in round-robin order wins, the second is rejected.

Test Plan:
- Reset, num_players=3 -> pos_x = {7,5,3,1} for players 3..0, pos_y all 1, facing all 10, outputs 0. Run one tick with no requests -> no ack, rr_ptr 0 -> 1.
- Player 0 at (1,1) requests right, grid_blocked=0 -> ack[0] within 5 cycles of tick, pos becomes (2,1), blocked[0]=0, facing 01.
- Player 0 at (0,y) requests left -> rejected as out of bounds, position unchanged, facing 11, blocked[0]=1. Same outcome for grid_blocked=1 on a legal tile.
- Players 0 and 1 both target (2,1) in the same tick with rr_ptr=1 -> player 1 moves, player 0 blocked=1. The next tick with rr_ptr=2 uses player-0-first ordering as checked by the order of ack pulses.
- Player 2 chops while at (5,1) facing down -> chop_valid one cycle with chop_player=2, chop_x=5, chop_y=2, no grid read, position unchanged.
- Three req_valid pulses for player 0 within one tick (up, down, left) -> only left is served. With num_players=0, requests on players 1..3 produce no ack. Reset asserted during LOOKUP -> positions return to spawn and busy=0 next cycle.

Source files
------------

// File: rtl/player_move_arbiter.sv
// player_move_arbiter: once per game tick, serves pending player move/chop
// requests in round-robin order. Each move reads the grid through one shared
// read port and is rejected if it goes off the board, hits a blocked tile, or
// lands on another active player. Players are served one at a time, so a
// later-served player sees the moves committed before it in the same sweep.
module player_move_arbiter #(
  parameter int TICK_CYCLES = 1083333,
  parameter int GRID_W      = 13,
  parameter int GRID_H      = 9
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic [1:0]  num_players,
  input  logic [3:0]  req_valid,
  input  logic [7:0]  req_dir,
  input  logic [3:0]  req_chop,
  output logic [3:0]  grid_rd_x,
  output logic [3:0]  grid_rd_y,
  input  logic        grid_blocked,
  output logic [15:0] pos_x,
  output logic [15:0] pos_y,
  output logic [7:0]  facing,
  output logic [3:0]  ack,
  output logic [3:0]  blocked,
  output logic        chop_valid,
  output logic [1:0]  chop_player,
  output logic [3:0]  chop_x,
  output logic [3:0]  chop_y,
  output logic        tick,
  output logic        busy
);

  localparam int              CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [4:0]      GW       = 5'(GRID_W);
  localparam logic [4:0]      GH       = 5'(GRID_H);

  // Spawn points: player i at (1+2i, 1), facing down.
  localparam logic [15:0] SPAWN_X = 16'h7531;
  localparam logic [15:0] SPAWN_Y = 16'h1111;
  localparam logic [7:0]  SPAWN_F = 8'hAA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_LOOKUP,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [3:0]       pending_q, pending_d;
  logic [7:0]       dir_lat_q, dir_lat_d;
  logic [3:0]       chop_lat_q, chop_lat_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       cur_dir_q, cur_dir_d;
  logic [1:0]       np_q, np_d;
  logic [3:0]       rd_x_q, rd_x_d;
  logic [3:0]       rd_y_q, rd_y_d;
  logic [15:0]      pos_x_q, pos_x_d;
  logic [15:0]      pos_y_q, pos_y_d;
  logic [7:0]       facing_q, facing_d;
  logic [3:0]       blocked_q, blocked_d;
  logic [3:0]       ack_q, ack_d;
  logic             chop_valid_q, chop_valid_d;
  logic [1:0]       chop_player_q, chop_player_d;
  logic [3:0]       chop_x_q, chop_x_d;
  logic [3:0]       chop_y_q, chop_y_d;

  logic             tick_wrap;
  logic             found;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             occupied;
  logic             reject;
  logic [3:0]       serve_clr;
  logic [3:0]       pick_x, pick_y;
  logic [1:0]       pick_dir, pick_face;
  logic [7:0]       move_xy, face_xy;

  // One grid step in direction d; 4-bit wrap so 0-1 becomes 15 (off-board).
  function automatic logic [7:0] step_xy(input logic [3:0] x, input logic [3:0] y,
                                         input logic [1:0] d);
    logic [3:0] nx;
    logic [3:0] ny;
    nx = x;
    ny = y;
    case (d)
      2'b00:   ny = y - 4'd1;
      2'b01:   nx = x + 4'd1;
      2'b10:   ny = y + 4'd1;
      default: nx = x - 4'd1;
    endcase
    return {nx, ny};
  endfunction

  assign tick_wrap = (cnt_q == CNT_LAST);

  // Round-robin pick: first set serve-mask bit at or after rr_ptr, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && mask_q[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Position/facing of the picked player and the tiles it would move to / faces.
  always_comb begin
    pick_x    = pos_x_q[{pick, 2'b00} +: 4];
    pick_y    = pos_y_q[{pick, 2'b00} +: 4];
    pick_dir  = dir_lat_q[{pick, 1'b0} +: 2];
    pick_face = facing_q[{pick, 1'b0} +: 2];
    move_xy   = step_xy(pick_x, pick_y, pick_dir);
    face_xy   = step_xy(pick_x, pick_y, pick_face);
  end

  // Target tile collides with another active player's current position.
  always_comb begin
    occupied = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if ((2'(j) != cur_q) && (2'(j) <= num_players) &&
          (pos_x_q[4*j +: 4] == rd_x_q) && (pos_y_q[4*j +: 4] == rd_y_q)) begin
        occupied = 1'b1;
      end
    end
  end

  assign reject = grid_blocked | ({1'b0, rd_x_q} >= GW) | ({1'b0, rd_y_q} >= GH) | occupied;

  // Next-state logic: tick counter, sweep FSM, commits and request capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = tick_wrap ? '0 : cnt_q + 1'b1;
    tick_d        = tick_wrap;
    pending_d     = pending_q;
    dir_lat_d     = dir_lat_q;
    chop_lat_d    = chop_lat_q;
    mask_d        = mask_q;
    rr_ptr_d      = rr_ptr_q;
    cur_d         = cur_q;
    cur_dir_d     = cur_dir_q;
    np_d          = num_players;
    rd_x_d        = rd_x_q;
    rd_y_d        = rd_y_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    facing_d      = facing_q;
    blocked_d     = blocked_q;
    ack_d         = 4'd0;
    chop_valid_d  = 1'b0;
    chop_player_d = chop_player_q;
    chop_x_d      = chop_x_q;
    chop_y_d      = chop_y_q;
    serve_clr     = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (tick_wrap) begin
          mask_d  = pending_q;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!found) begin
          rr_ptr_d = rr_ptr_q + 2'd1;
          state_d  = S_IDLE;
        end else if (chop_lat_q[pick]) begin
          chop_valid_d    = 1'b1;
          chop_player_d   = pick;
          chop_x_d        = face_xy[7:4];
          chop_y_d        = face_xy[3:0];
          ack_d[pick]     = 1'b1;
          serve_clr[pick] = 1'b1;
        end else begin
          cur_d     = pick;
          cur_dir_d = pick_dir;
          rd_x_d    = move_xy[7:4];
          rd_y_d    = move_xy[3:0];
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        facing_d[{cur_q, 1'b0} +: 2] = cur_dir_q;
        if (!reject) begin
          pos_x_d[{cur_q, 2'b00} +: 4] = rd_x_q;
          pos_y_d[{cur_q, 2'b00} +: 4] = rd_y_q;
        end
        blocked_d[cur_q] = reject;
        ack_d[cur_q]     = 1'b1;
        serve_clr[cur_q] = 1'b1;
        state_d          = S_SCAN;
      end
      default: state_d = S_IDLE;
    endcase

    mask_d    = mask_d & ~serve_clr;
    pending_d = pending_d & ~serve_clr;

    // Players dropped from the active set lose anything they had queued.
    if (num_players != np_q) begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) > num_players) pending_d[i] = 1'b0;
      end
    end

    // New requests win over a same-cycle serve clear and overwrite older ones.
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && (2'(i) <= num_players)) begin
        pending_d[i]        = 1'b1;
        dir_lat_d[2*i +: 2] = req_dir[2*i +: 2];
        chop_lat_d[i]       = req_chop[i];
      end
    end
  end

  // State registers with synchronous active-low reset; reset abandons any sweep.
  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      tick_q        <= 1'b0;
      pending_q     <= 4'd0;
      dir_lat_q     <= 8'd0;
      chop_lat_q    <= 4'd0;
      mask_q        <= 4'd0;
      rr_ptr_q      <= 2'd0;
      cur_q         <= 2'd0;
      cur_dir_q     <= 2'd0;
      np_q          <= 2'd0;
      rd_x_q        <= 4'd0;
      rd_y_q        <= 4'd0;
      pos_x_q       <= SPAWN_X;
      pos_y_q       <= SPAWN_Y;
      facing_q      <= SPAWN_F;
      blocked_q     <= 4'd0;
      ack_q         <= 4'd0;
      chop_valid_q  <= 1'b0;
      chop_player_q <= 2'd0;
      chop_x_q      <= 4'd0;
      chop_y_q      <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tick_q        <= tick_d;
      pending_q     <= pending_d;
      dir_lat_q     <= dir_lat_d;
      chop_lat_q    <= chop_lat_d;
      mask_q        <= mask_d;
      rr_ptr_q      <= rr_ptr_d;
      cur_q         <= cur_d;
      cur_dir_q     <= cur_dir_d;
      np_q          <= np_d;
      rd_x_q        <= rd_x_d;
      rd_y_q        <= rd_y_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      facing_q      <= facing_d;
      blocked_q     <= blocked_d;
      ack_q         <= ack_d;
      chop_valid_q  <= chop_valid_d;
      chop_player_q <= chop_player_d;
      chop_x_q      <= chop_x_d;
      chop_y_q      <= chop_y_d;
    end
  end

  assign grid_rd_x   = rd_x_q;
  assign grid_rd_y   = rd_y_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign facing      = facing_q;
  assign ack         = ack_q;
  assign blocked     = blocked_q;
  assign chop_valid  = chop_valid_q;
  assign chop_player = chop_player_q;
  assign chop_x      = chop_x_q;
  assign chop_y      = chop_y_q;
  assign tick        = tick_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_player_move_arbiter.sv
// Directed bench for player_move_arbiter with a short tick period.
module tb_player_move_arbiter;

  localparam int TICKS = 24;

  logic        clock_in = 1'b0;
  logic        reset_in;
  logic [1:0]  num_players;
  logic [3:0]  req_valid;
  logic [7:0]  req_dir;
  logic [3:0]  req_chop;
  logic [3:0]  grid_rd_x, grid_rd_y;
  logic        grid_blocked;
  logic [15:0] pos_x, pos_y;
  logic [7:0]  facing;
  logic [3:0]  ack, blocked;
  logic        chop_valid;
  logic [1:0]  chop_player;
  logic [3:0]  chop_x, chop_y;
  logic        tick, busy;

  player_move_arbiter #(.TICK_CYCLES(TICKS), .GRID_W(13), .GRID_H(9)) dut (
    .clock_in(clock_in), .reset_in(reset_in), .num_players(num_players),
    .req_valid(req_valid), .req_dir(req_dir), .req_chop(req_chop),
    .grid_rd_x(grid_rd_x), .grid_rd_y(grid_rd_y), .grid_blocked(grid_blocked),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .ack(ack), .blocked(blocked),
    .chop_valid(chop_valid), .chop_player(chop_player), .chop_x(chop_x),
    .chop_y(chop_y), .tick(tick), .busy(busy)
  );

  always #5 clock_in = ~clock_in;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] acc_ack, seq0, seq1;
  int         n_acks, lat_first, n_chops;
  logic [1:0] cp;
  logic [3:0] cx, cy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v, input logic [7:0] d, input logic [3:0] c);
    req_valid = v;
    req_dir   = d;
    req_chop  = c;
    step();
    req_valid = 4'd0;
    req_dir   = 8'd0;
    req_chop  = 4'd0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  // Waits for a tick, then follows the sweep recording ack order and chops.
  task automatic run_tick();
    int c;
    wait_tick();
    acc_ack = 4'd0; seq0 = 4'd0; seq1 = 4'd0;
    n_acks = 0; lat_first = -1; n_chops = 0; c = 0;
    while (busy === 1'b1 && c < 40) begin
      step();
      c++;
      if (ack !== 4'd0) begin
        acc_ack |= ack;
        if (n_acks == 0) begin
          seq0      = ack;
          lat_first = c;
        end else if (n_acks == 1) begin
          seq1 = ack;
        end
        n_acks++;
      end
      if (chop_valid === 1'b1) begin
        n_chops++;
        cp = chop_player;
        cx = chop_x;
        cy = chop_y;
      end
    end
    chk("sweep_done", 32'(busy), 32'd0);
  endtask

  initial begin
    reset_in = 1'b0; num_players = 2'd3; req_valid = 4'd0; req_dir = 8'd0;
    req_chop = 4'd0; grid_blocked = 1'b0;
    repeat (3) step();
    chk("rst_pos_x", 32'(pos_x), 32'h7531);
    chk("rst_pos_y", 32'(pos_y), 32'h1111);
    chk("rst_facing", 32'(facing), 32'hAA);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_blocked", 32'(blocked), 32'd0);
    chk("rst_chop_valid", 32'(chop_valid), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grid_rd", 32'({grid_rd_y, grid_rd_x}), 32'd0);
    reset_in = 1'b1;

    // Empty tick: no acks, rr_ptr 0 -> 1.
    run_tick();
    chk("idle_no_ack", 32'(acc_ack), 32'd0);

    // Player 0 right from (1,1) to (2,1).
    pulse(4'b0001, 8'h01, 4'd0);
    run_tick();
    chk("mv_ack", 32'(seq0), 32'h1);
    chk("mv_lat", 32'(lat_first > 0 && lat_first <= 5), 32'd1);
    chk("mv_pos_x", 32'(pos_x[3:0]), 32'd2);
    chk("mv_pos_y", 32'(pos_y[3:0]), 32'd1);
    chk("mv_blocked", 32'(blocked[0]), 32'd0);
    chk("mv_facing", 32'(facing[1:0]), 32'd1);
    chk("mv_others", 32'(pos_x[15:4]), 32'h753);

    // Walk left to x=0, then one more left is off the board.
    pulse(4'b0001, 8'h03, 4'd0);
    run_tick();
    chk("l1_pos_x", 32'(pos_x[3:0]), 32'd1);
    pulse(4'b0001, 8'h03, 4'd0);
    run_tick();
    chk("l2_pos_x", 32'(pos_x[3:0]), 32'd0);
    chk("l2_blocked", 32'(blocked[0]), 32'd0);
    pulse(4'b0001, 8'h03, 4'd0);
    run_tick();
    chk("oob_ack", 32'(seq0), 32'h1);
    chk("oob_pos_x", 32'(pos_x[3:0]), 32'd0);
    chk("oob_pos_y", 32'(pos_y[3:0]), 32'd1);
    chk("oob_facing", 32'(facing[1:0]), 32'd3);
    chk("oob_blocked", 32'(blocked[0]), 32'd1);

    // Legal tile (1,1) reported blocked by the grid.
    grid_blocked = 1'b1;
    pulse(4'b0001, 8'h01, 4'd0);
    run_tick();
    grid_blocked = 1'b0;
    chk("gb_rd", 32'({grid_rd_y, grid_rd_x}), 32'h11);
    chk("gb_pos_x", 32'(pos_x[3:0]), 32'd0);
    chk("gb_facing", 32'(facing[1:0]), 32'd1);
    chk("gb_blocked", 32'(blocked[0]), 32'd1);

    // Now actually move to (1,1); rr_ptr goes 2 -> 3.
    pulse(4'b0001, 8'h01, 4'd0);
    run_tick();
    chk("r_pos_x", 32'(pos_x[3:0]), 32'd1);
    chk("r_blocked", 32'(blocked[0]), 32'd0);

    // Two empty ticks bring rr_ptr to 1.
    run_tick();
    run_tick();

    // P0 right and P1 left both target (2,1); P1 is served first.
    pulse(4'b0011, 8'b0000_1101, 4'd0);
    run_tick();
    chk("ct_first", 32'(seq0), 32'h2);
    chk("ct_second", 32'(seq1), 32'h1);
    chk("ct_p1_x", 32'(pos_x[7:4]), 32'd2);
    chk("ct_p0_x", 32'(pos_x[3:0]), 32'd1);
    chk("ct_blocked", 32'(blocked[1:0]), 32'b01);

    // rr_ptr=2: P0 is served before P1; both move up.
    pulse(4'b0011, 8'h00, 4'd0);
    run_tick();
    chk("ord_first", 32'(seq0), 32'h1);
    chk("ord_second", 32'(seq1), 32'h2);
    chk("ord_pos_y", 32'(pos_y[7:0]), 32'h00);
    chk("ord_blocked", 32'(blocked[1:0]), 32'd0);

    // P2 at (5,1) facing down chops tile (5,2); no grid read.
    pulse(4'b0100, 8'h00, 4'b0100);
    run_tick();
    chk("ch_count", 32'(n_chops), 32'd1);
    chk("ch_player", 32'(cp), 32'd2);
    chk("ch_x", 32'(cx), 32'd5);
    chk("ch_y", 32'(cy), 32'd2);
    chk("ch_ack", 32'(acc_ack), 32'h4);
    chk("ch_rd", 32'({grid_rd_y, grid_rd_x}), 32'h02);
    chk("ch_pos", 32'({pos_x[11:8], pos_y[11:8]}), 32'h51);
    chk("ch_facing", 32'(facing[5:4]), 32'd2);

    // Latest request wins: up, down, left -> only left served, (1,0) -> (0,0).
    pulse(4'b0001, 8'h00, 4'd0);
    pulse(4'b0001, 8'h02, 4'd0);
    pulse(4'b0001, 8'h03, 4'd0);
    run_tick();
    chk("lw_nacks", 32'(n_acks), 32'd1);
    chk("lw_pos", 32'({pos_x[3:0], pos_y[3:0]}), 32'h00);
    chk("lw_facing", 32'(facing[1:0]), 32'd3);

    // P1 queues, then num_players drops to 0; inactive requests ignored.
    pulse(4'b0010, 8'b0000_0100, 4'd0);
    num_players = 2'd0;
    step();
    pulse(4'b1110, 8'b0101_0100, 4'd0);
    run_tick();
    chk("inact_ack", 32'(acc_ack), 32'd0);
    chk("inact_p1_x", 32'(pos_x[7:4]), 32'd2);
    num_players = 2'd3;
    step();

    // Reset during LOOKUP of P0 moving right to (1,0).
    pulse(4'b0001, 8'h01, 4'd0);
    wait_tick();
    step();
    chk("rl_busy_lookup", 32'(busy), 32'd1);
    chk("rl_rd", 32'({grid_rd_y, grid_rd_x}), 32'h01);
    reset_in = 1'b0;
    step();
    chk("rl_pos_x", 32'(pos_x), 32'h7531);
    chk("rl_pos_y", 32'(pos_y), 32'h1111);
    chk("rl_facing", 32'(facing), 32'hAA);
    chk("rl_busy", 32'(busy), 32'd0);
    chk("rl_ack", 32'(ack), 32'd0);
    chk("rl_blocked", 32'(blocked), 32'd0);
    chk("rl_grid_rd", 32'({grid_rd_y, grid_rd_x}), 32'd0);
    reset_in = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
